// File: rtl/rvv_boot_ctrl.sv
// rtl/rvv_boot_ctrl.sv - bring-up sequencer driving the core wrapper AXI write channels
//
// Purpose:
//   Owns the AW/W/B channels of the core wrapper's AXI slave port.
//   LOAD : each accepted host word-write becomes one single-beat AXI write.
//   START: writes start PC, then the run value, into the core CSR block.
//   RUN  : watches core_halted / core_fault with an optional timeout and
//          reports done / error with an error code.
//
// Ports:
//   io_aclk, io_aresetn              clock, asynchronous active-low reset
//   ld_valid/ld_ready/ld_addr/ld_data host word-write request
//   start, start_pc                   start command and start PC
//   tmo_cycles                        run timeout in cycles (0 disables)
//   clr                               leave DONE/ERR back to IDLE
//   busy, done, error, err_code       status (err_code 1 BRESP, 2 timeout, 3 fault)
//   aw_*, w_*, b_*                    AXI write address / data / response channels
//   core_halted, core_fault           core status inputs

module rvv_boot_ctrl #(
  parameter logic [31:0] CSR_BASE    = 32'h0003_0000,
  parameter logic [31:0] PC_OFFSET   = 32'h0000_0004,
  parameter logic [31:0] CTRL_OFFSET = 32'h0000_0000,
  parameter logic [31:0] RUN_VAL     = 32'h0000_0001,
  parameter int          TMO_W       = 24
) (
  input  logic             io_aclk,
  input  logic             io_aresetn,

  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [31:0]      ld_addr,
  input  logic [31:0]      ld_data,

  input  logic             start,
  input  logic [31:0]      start_pc,
  input  logic [TMO_W-1:0] tmo_cycles,
  input  logic             clr,

  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code,

  output logic             aw_valid,
  input  logic             aw_ready,
  output logic [31:0]      aw_addr,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [31:0]      w_data,
  output logic [3:0]       w_strb,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_resp,

  input  logic             core_halted,
  input  logic             core_fault
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_ISSUE = 3'd1;
  localparam logic [2:0] S_WR_RESP  = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  // Tag carried with each write so WR_RESP knows what comes next.
  localparam logic [1:0] PH_LOAD = 2'd0;
  localparam logic [1:0] PH_PC   = 2'd1;
  localparam logic [1:0] PH_CTRL = 2'd2;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BRESP = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_FAULT = 2'd3;

  localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [1:0]       phase;
  logic [TMO_W-1:0] run_cnt;
  logic             aw_valid_q;
  logic             w_valid_q;
  logic [31:0]      aw_addr_q;
  logic [31:0]      w_data_q;
  logic [1:0]       err_code_q;

  logic aw_fire;
  logic w_fire;
  logic issue_done;
  logic tmo_hit;

  assign aw_fire = aw_valid_q & aw_ready;
  assign w_fire  = w_valid_q & w_ready;

  // A channel counts as finished if its valid already dropped or it
  // handshakes this cycle; both may complete in the same cycle.
  assign issue_done = (!aw_valid_q || aw_ready) && (!w_valid_q || w_ready);

  assign tmo_hit = (tmo_cycles != '0) && (run_cnt == (tmo_cycles - CNT_ONE));

  always_ff @(posedge io_aclk or negedge io_aresetn) begin
    if (!io_aresetn) begin
      state      <= S_IDLE;
      phase      <= PH_LOAD;
      run_cnt    <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state)
        S_IDLE: begin
          // Load has priority; a start held across the load is seen on return.
          if (ld_valid) begin
            aw_addr_q  <= ld_addr;
            w_data_q   <= ld_data;
            phase      <= PH_LOAD;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            state      <= S_WR_ISSUE;
          end else if (start) begin
            aw_addr_q  <= CSR_BASE + PC_OFFSET;
            w_data_q   <= start_pc;
            phase      <= PH_PC;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            state      <= S_WR_ISSUE;
          end
        end

        S_WR_ISSUE: begin
          if (aw_fire) begin
            aw_valid_q <= 1'b0;
          end
          if (w_fire) begin
            w_valid_q <= 1'b0;
          end
          if (issue_done) begin
            state <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (b_valid) begin
            if (b_resp != 2'b00) begin
              err_code_q <= ERR_BRESP;
              state      <= S_ERR;
            end else begin
              case (phase)
                PH_PC: begin
                  aw_addr_q  <= CSR_BASE + CTRL_OFFSET;
                  w_data_q   <= RUN_VAL;
                  phase      <= PH_CTRL;
                  aw_valid_q <= 1'b1;
                  w_valid_q  <= 1'b1;
                  state      <= S_WR_ISSUE;
                end
                PH_CTRL: begin
                  run_cnt <= '0;
                  state   <= S_RUN;
                end
                default: begin
                  state <= S_IDLE;
                end
              endcase
            end
          end
        end

        S_RUN: begin
          // Saturate rather than wrap so a disabled timeout never aliases.
          if (run_cnt != '1) begin
            run_cnt <= run_cnt + CNT_ONE;
          end
          if (core_fault) begin
            err_code_q <= ERR_FAULT;
            state      <= S_ERR;
          end else if (core_halted) begin
            state <= S_DONE;
          end else if (tmo_hit) begin
            err_code_q <= ERR_TMO;
            state      <= S_ERR;
          end
        end

        S_DONE, S_ERR: begin
          if (clr) begin
            err_code_q <= ERR_NONE;
            state      <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ld_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE) && (state != S_DONE) && (state != S_ERR);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign err_code = err_code_q;

  assign aw_valid = aw_valid_q;
  assign aw_addr  = aw_addr_q;
  assign w_valid  = w_valid_q;
  assign w_data   = w_data_q;
  assign w_strb   = 4'hF;
  assign b_ready  = (state == S_WR_RESP);

endmodule
